mult_scheduler: RTL

Sequencer and arbiter that shares one 8x8 shift-add multiplier datapath between two requesters. The datapath consists of the A/Q shift registers, the B register, the adder, the carry flip-flop, the step counter and the zero detector. The block accepts operand pairs over a req/ack handshake and grants requesters round-robin. It drives the datapath control strobes and counts iterations through the datapath's zero flag. It returns each 16-bit product to its own requester with a one-cycle done pulse. It sits between the switch/button front end and the multiplier datapath, replacing direct button-driven control.

---
 rtl/mult_scheduler_pkg.sv | 16 +
 rtl/mult_scheduler_if.sv | 22 ++
 rtl/mult_scheduler_rr_arbiter2.sv | 27 ++
 rtl/mult_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mult_scheduler_pkg.sv
// Shared definitions for the two-requester shift-add multiplier scheduler:
// FSM state encoding and default datapath sizing.
package mult_scheduler_pkg;

  localparam int N_BITS_DEF   = 8;
  localparam int CNT_INIT_DEF = N_BITS_DEF - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mult_scheduler_if.sv
// Requester-side bundle: two req/ack operand channels and their done/result returns.
interface mult_scheduler_if
  import mult_scheduler_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
);
  logic                  req0, req1;
  logic [N_BITS-1:0]     a0, b0, a1, b1;
  logic                  ack0, ack1;
  logic                  done0, done1;
  logic [2*N_BITS-1:0]   res0, res1;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  ack0, ack1, done0, done1, res0, res1
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output ack0, ack1, done0, done1, res0, res1
  );
endinterface

// File: rtl/mult_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the last_grant register only advances when
// the caller says a grant is actually taken.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  input  logic en_i,
  output logic gnt_o,
  output logic vld_o
);
  logic last_q, last_d;

  always_comb begin
    vld_o = req0_i | req1_i;
    // On a tie the requester that did not win last time goes first.
    if (req0_i && req1_i) gnt_o = ~last_q;
    else                  gnt_o = req1_i;
    last_d = last_q;
    if (en_i && vld_o) last_d = gnt_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/mult_scheduler.sv
// Sequencer that time-shares one shift-add multiplier datapath between two
// requesters: grants round-robin, drives the datapath strobes, returns products.
module mult_scheduler
  import mult_scheduler_pkg::*;
#(
  parameter int N_BITS   = N_BITS_DEF,
  parameter int CNT_INIT = CNT_INIT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_scheduler_if.slave     rq,
  output logic [N_BITS-1:0]   dp_b,
  output logic [N_BITS-1:0]   dp_q,
  output logic                load_a,
  output logic                load_q,
  output logic                load_b,
  output logic                load_p,
  output logic                reset_a,
  output logic                reset_c,
  output logic                dec_c,
  output logic                shift,
  input  logic                z,
  input  logic                q0,
  input  logic [2*N_BITS-1:0] dp_prod
);
  if (CNT_INIT != N_BITS - 1) begin : g_bad_cnt_init
    $error("CNT_INIT must equal N_BITS-1 for N_BITS shifts");
  end

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [N_BITS-1:0]     dp_b_q, dp_b_d, dp_q_q, dp_q_d;
  logic [2*N_BITS-1:0]   res0_q, res0_d, res1_q, res1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  gnt, gnt_vld, arb_en;

  assign arb_en = (state_q == S_IDLE);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0_i (rq.req0),
    .req1_i (rq.req1),
    .en_i   (arb_en),
    .gnt_o  (gnt),
    .vld_o  (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    dp_b_d  = dp_b_q;
    dp_q_d  = dp_q_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    load_a  = 1'b0;
    load_q  = 1'b0;
    load_b  = 1'b0;
    load_p  = 1'b0;
    reset_a = 1'b0;
    reset_c = 1'b0;
    dec_c   = 1'b0;
    shift   = 1'b0;
    rq.ack0 = 1'b0;
    rq.ack1 = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt;
          dp_b_d  = gnt ? rq.a1 : rq.a0;
          dp_q_d  = gnt ? rq.b1 : rq.b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load_b  = 1'b1;
        load_q  = 1'b1;
        load_p  = 1'b1;
        reset_a = 1'b1;
        reset_c = 1'b1;
        rq.ack0 = ~owner_q;
        rq.ack1 = owner_q;
        state_d = S_ADD;
      end
      S_ADD: begin
        load_a  = q0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // The counter value 0 is still shifted, so CNT_INIT..0 gives N_BITS shifts.
        shift = 1'b1;
        if (z) begin
          state_d = S_DONE;
        end else begin
          dec_c   = 1'b1;
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        if (owner_q) begin
          res1_d  = dp_prod;
          done1_d = 1'b1;
        end else begin
          res0_d  = dp_prod;
          done0_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      dp_b_q  <= '0;
      dp_q_q  <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      dp_b_q  <= dp_b_d;
      dp_q_q  <= dp_q_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign dp_b     = dp_b_q;
  assign dp_q     = dp_q_q;
  assign rq.res0  = res0_q;
  assign rq.res1  = res1_q;
  assign rq.done0 = done0_q;
  assign rq.done1 = done1_q;
endmodule
